// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stage-latch enable/bubble sequencer for the RV32 pipeline (optional PIPE_HAZARD_CTRL_PERF_EN counters)
module pipeline_hazard_ctrl #(
    parameter int LUSE_CYC  = 1,
    parameter int FLUSH_CYC = 1,
    parameter int MEM_TMO   = 255
) (
    input  logic        stg_clk,
    input  logic        reset,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        dec_rs1_used,
    input  logic        dec_rs2_used,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rd_memory,
    input  logic        ex_save_to_reg,
    input  logic        br_resolve,
    input  logic        br_mispredict,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic [4:0]  stg_ena,
    output logic [4:0]  stg_x,
    output logic        redirect,
    output logic        stalled,
    output logic        mem_err,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_RUN,
        ST_LUSE,
        ST_FLUSH,
        ST_MEM_WAIT
    } state_t;

    localparam logic [7:0] LUSE_LEN  = 8'(LUSE_CYC - 1);
    localparam logic [7:0] FLUSH_LEN = 8'(FLUSH_CYC - 1);
    localparam logic [7:0] TMO_LIM   = 8'(MEM_TMO);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mem_err_q, mem_err_d;
    logic       hazard;
    logic       mispredict;
    logic       mem_hold;

    always_comb begin
        hazard = ex_valid & ex_rd_memory & ex_save_to_reg & (ex_rd != 5'd0) & dec_valid
               & ((dec_rs1_used & (dec_rs1 == ex_rd)) | (dec_rs2_used & (dec_rs2 == ex_rd)));
        mispredict = br_resolve & br_mispredict;
        mem_hold   = mem_req & ~mem_ready;
    end

    // cnt_q holds remaining LUSE/FLUSH cycles, or elapsed MEM_WAIT cycles
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        stg_ena   = 5'b11111;
        stg_x     = 5'b00000;
        redirect  = 1'b0;
        case (state_q)
            ST_INIT: begin
                stg_x   = 5'b11111;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mem_hold) begin
                    stg_ena = 5'b10000;
                    stg_x   = 5'b10000;
                    cnt_d   = 8'd0;
                    state_d = ST_MEM_WAIT;
                end else if (mispredict) begin
                    stg_x    = 5'b00110;
                    redirect = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        cnt_d   = FLUSH_LEN;
                        state_d = ST_FLUSH;
                    end
                end else if (hazard) begin
                    stg_ena = 5'b11100;
                    stg_x   = 5'b00100;
                    if (LUSE_CYC > 1) begin
                        cnt_d   = LUSE_LEN;
                        state_d = ST_LUSE;
                    end
                end
            end
            ST_LUSE: begin
                stg_ena = 5'b11100;
                stg_x   = 5'b00100;
                if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_FLUSH: begin
                if (mispredict) begin
                    stg_x    = 5'b00110;
                    redirect = 1'b1;
                    cnt_d    = FLUSH_LEN;
                end else begin
                    stg_x = 5'b00010;
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_RUN;
                end else if (cnt_q == TMO_LIM) begin
                    stg_x     = 5'b01000;
                    mem_err_d = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    stg_ena = 5'b10000;
                    stg_x   = 5'b10000;
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        if (reset) begin
            stg_ena  = 5'b11111;
            stg_x    = 5'b11111;
            redirect = 1'b0;
        end
        stalled = reset | (state_q != ST_RUN) | hazard;
    end

    always_ff @(posedge stg_clk) begin
        if (reset) begin
            state_q   <= ST_INIT;
            cnt_q     <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stalled && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (redirect && (perf_flush_q != 32'hFFFF_FFFF)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    always_ff @(posedge stg_clk) begin
        if (reset) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`else
    assign perf_stall = 32'd0;
    assign perf_flush = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized bench for pipeline_hazard_ctrl against a counter-based reference model
module tb_pipeline_hazard_ctrl;

    localparam int LUSE_CYC  = 1;
    localparam int FLUSH_CYC = 2;
    localparam int MEM_TMO   = 8;

    logic        stg_clk = 1'b0;
    logic        reset;
    logic        dec_valid, dec_rs1_used, dec_rs2_used;
    logic [4:0]  dec_rs1, dec_rs2, ex_rd;
    logic        ex_valid, ex_rd_memory, ex_save_to_reg;
    logic        br_resolve, br_mispredict, mem_req, mem_ready;
    logic [4:0]  stg_ena, stg_x;
    logic        redirect, stalled, mem_err;
    logic [31:0] perf_stall, perf_flush;

    pipeline_hazard_ctrl #(
        .LUSE_CYC (LUSE_CYC),
        .FLUSH_CYC(FLUSH_CYC),
        .MEM_TMO  (MEM_TMO)
    ) dut (
        .stg_clk       (stg_clk),
        .reset         (reset),
        .dec_valid     (dec_valid),
        .dec_rs1       (dec_rs1),
        .dec_rs2       (dec_rs2),
        .dec_rs1_used  (dec_rs1_used),
        .dec_rs2_used  (dec_rs2_used),
        .ex_valid      (ex_valid),
        .ex_rd         (ex_rd),
        .ex_rd_memory  (ex_rd_memory),
        .ex_save_to_reg(ex_save_to_reg),
        .br_resolve    (br_resolve),
        .br_mispredict (br_mispredict),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .stg_ena       (stg_ena),
        .stg_x         (stg_x),
        .redirect      (redirect),
        .stalled       (stalled),
        .mem_err       (mem_err),
        .perf_stall    (perf_stall),
        .perf_flush    (perf_flush)
    );

    always #5 stg_clk = ~stg_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: remaining-cycle counters rather than a state register
    bit       m_known = 0;
    bit       m_init, m_wait_on, m_err;
    int       m_luse, m_flush, m_wait;
    longint   m_ps, m_pf;
    bit       n_init, n_wait_on, n_err;
    int       n_luse, n_flush, n_wait;
    longint   n_ps, n_pf;
    logic [4:0] e_ena, e_x;
    logic       e_red, e_stalled;

    task automatic model_eval();
        bit haz;
        haz = ex_valid && ex_rd_memory && ex_save_to_reg && (ex_rd != 0) && dec_valid &&
              ((dec_rs1_used && dec_rs1 == ex_rd) || (dec_rs2_used && dec_rs2 == ex_rd));
        n_init = 0; n_luse = m_luse; n_flush = m_flush;
        n_wait_on = m_wait_on; n_wait = m_wait; n_err = m_err;
        e_ena = 5'b11111; e_x = 5'b00000; e_red = 0; e_stalled = 1;
        if (reset) begin
            e_x = 5'b11111; n_init = 1; n_luse = 0; n_flush = 0;
            n_wait_on = 0; n_wait = 0; n_err = 0;
        end else if (m_init) begin
            e_x = 5'b11111;
        end else if (m_wait_on) begin
            if (mem_ready) n_wait_on = 0;
            else if (m_wait == MEM_TMO) begin
                e_x = 5'b01000; n_err = 1; n_wait_on = 0;
            end else begin
                e_ena = 5'b10000; e_x = 5'b10000; n_wait = m_wait + 1;
            end
        end else if (m_flush > 0) begin
            if (br_resolve && br_mispredict) begin
                e_x = 5'b00110; e_red = 1; n_flush = FLUSH_CYC - 1;
            end else begin
                e_x = 5'b00010; n_flush = m_flush - 1;
            end
        end else if (m_luse > 0) begin
            e_ena = 5'b11100; e_x = 5'b00100; n_luse = m_luse - 1;
        end else begin
            e_stalled = haz;
            if (mem_req && !mem_ready) begin
                e_ena = 5'b10000; e_x = 5'b10000; n_wait_on = 1; n_wait = 0;
            end else if (br_resolve && br_mispredict) begin
                e_x = 5'b00110; e_red = 1; n_flush = FLUSH_CYC - 1;
            end else if (haz) begin
                e_ena = 5'b11100; e_x = 5'b00100; n_luse = LUSE_CYC - 1;
            end
        end
        if (reset) begin
            n_ps = 0; n_pf = 0;
        end else begin
            n_ps = (e_stalled && m_ps < 64'hFFFF_FFFF) ? m_ps + 1 : m_ps;
            n_pf = (e_red && m_pf < 64'hFFFF_FFFF) ? m_pf + 1 : m_pf;
        end
    endtask

    // Called just after a falling edge with inputs already driven
    task automatic step();
        logic [31:0] exp_ps, exp_pf;
        #1;
        model_eval();
        check_eq("stg_ena", stg_ena, e_ena);
        check_eq("stg_x", stg_x, e_x);
        check_eq("redirect", redirect, e_red);
        check_eq("stalled", stalled, e_stalled);
        if (m_known) begin
`ifdef PIPE_HAZARD_CTRL_PERF_EN
            exp_ps = m_ps[31:0]; exp_pf = m_pf[31:0];
`else
            exp_ps = 32'd0; exp_pf = 32'd0;
`endif
            check_eq("mem_err", mem_err, m_err);
            check_eq("perf_stall", perf_stall, exp_ps);
            check_eq("perf_flush", perf_flush, exp_pf);
        end
        @(posedge stg_clk);
        m_init = n_init; m_luse = n_luse; m_flush = n_flush;
        m_wait_on = n_wait_on; m_wait = n_wait; m_err = n_err;
        m_ps = n_ps; m_pf = n_pf;
        if (reset) m_known = 1;
        cyc++;
        @(negedge stg_clk);
    endtask

    task automatic idle_inputs();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
        ex_valid = 0; ex_rd = 0; ex_rd_memory = 0; ex_save_to_reg = 0;
        br_resolve = 0; br_mispredict = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] ena, input logic [4:0] x);
        #1;
        check_eq({tag, "_ena"}, stg_ena, ena);
        check_eq({tag, "_x"}, stg_x, x);
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        m_init = 1; m_wait_on = 0; m_err = 0; m_luse = 0; m_flush = 0; m_wait = 0;
        m_ps = 0; m_pf = 0;
        @(negedge stg_clk);
        step();
        step();
        reset = 0;
        expect_out("init", 5'b11111, 5'b11111);
        step();
        expect_out("run", 5'b11111, 5'b00000);
        step();

        ex_valid = 1; ex_rd_memory = 1; ex_save_to_reg = 1; ex_rd = 5;
        dec_valid = 1; dec_rs2 = 5; dec_rs2_used = 1;
        expect_out("luse", 5'b11100, 5'b00100);
        check_eq("luse_stalled", stalled, 1'b1);
        step();
        idle_inputs();
        expect_out("luse_after", 5'b11111, 5'b00000);
        step();

        ex_valid = 1; ex_rd_memory = 1; ex_save_to_reg = 1; ex_rd = 0;
        dec_valid = 1; dec_rs2 = 0; dec_rs2_used = 1;
        expect_out("rd0", 5'b11111, 5'b00000);
        check_eq("rd0_stalled", stalled, 1'b0);
        step();
        idle_inputs();

        br_resolve = 1; br_mispredict = 1;
        expect_out("mp", 5'b11111, 5'b00110);
        check_eq("mp_redirect", redirect, 1'b1);
        step();
        idle_inputs();
        expect_out("flush", 5'b11111, 5'b00010);
        check_eq("flush_redirect", redirect, 1'b0);
        step();
        expect_out("flush_done", 5'b11111, 5'b00000);
        step();

        mem_req = 1; mem_ready = 0; br_resolve = 1; br_mispredict = 1;
        for (int i = 0; i < 4; i++) begin
            expect_out("mwait", 5'b10000, 5'b10000);
            check_eq("mwait_redirect", redirect, 1'b0);
            step();
        end
        mem_ready = 1;
        expect_out("mready", 5'b11111, 5'b00000);
        step();
        idle_inputs();
        step();

        mem_req = 1; mem_ready = 0;
        for (int i = 0; i <= MEM_TMO; i++) begin
            expect_out("tmo_wait", 5'b10000, 5'b10000);
            step();
        end
        expect_out("tmo", 5'b11111, 5'b01000);
        step();
        idle_inputs();
        check_eq("tmo_mem_err", mem_err, 1'b1);
        expect_out("tmo_run", 5'b11111, 5'b00000);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        check_eq("tmo_perf_ge8", perf_stall >= 32'd8, 1'b1);
`endif
        step();

        for (int i = 0; i < 2000; i++) begin
            reset          = ($urandom_range(0, 199) == 0);
            dec_valid      = $urandom_range(0, 3) != 0;
            dec_rs1        = 5'($urandom_range(0, 3));
            dec_rs2        = 5'($urandom_range(0, 3));
            dec_rs1_used   = $urandom_range(0, 1) == 1;
            dec_rs2_used   = $urandom_range(0, 1) == 1;
            ex_valid       = $urandom_range(0, 3) != 0;
            ex_rd          = 5'($urandom_range(0, 3));
            ex_rd_memory   = $urandom_range(0, 1) == 1;
            ex_save_to_reg = $urandom_range(0, 3) != 0;
            br_resolve     = $urandom_range(0, 3) == 0;
            br_mispredict  = $urandom_range(0, 1) == 1;
            mem_req        = $urandom_range(0, 3) == 0;
            mem_ready      = $urandom_range(0, 2) == 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
